// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU core: opcode values, FSM state
// encoding and bit positions inside the {Z,N,C,V} flag vector.
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_DBL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (clears all state)
//   start       load a/b and process multiplier bit 0 on this edge
//   a, b        WIDTH-bit unsigned operands (sampled only when start=1)
//   done        high from the edge the last bit is processed until next start
//   prod        2*WIDTH-bit product, valid while done=1
module alu_mul_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   done,
  output logic [2*WIDTH-1:0]     prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

  // Bit 0 is folded into the load edge, so WIDTH edges in total (start
  // plus WIDTH-1 busy steps) cover all multiplier bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      prod   <= '0;
    end else if (start) begin
      prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt    <= CW'(1);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      if (mplier[0]) begin
        prod <= prod + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(WIDTH-1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops (NOT/ADD/SUB/DBL/AND/OR/XOR) complete on the accept edge;
// MUL runs on the iterative multiplier and completes WIDTH+1 clocks later.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   in_valid, in_ready  input handshake (a, b, op captured on accept)
//   a, b, op            operands and 3-bit opcode
//   out_valid,out_ready output handshake
//   y, flags            result and {Z,N,C,V}, held while out_valid=1
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  state_t state;

  logic accept;
  logic mul_start;
  logic mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // Accepting in DONE requires out_ready, so a new op always coincides with
  // consumption of the held result.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle datapath: one shared adder serves ADD (a+b),
  // SUB (a+~b+1) and DBL (a+a).
  logic [WIDTH-1:0] opnd_b;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c_f;
  logic             v_f;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] mul_lo;
  logic [3:0]       mul_flags;

  always_comb begin
    opnd_b = b;
    cin    = 1'b0;
    case (op)
      OP_SUB: begin
        opnd_b = ~b;
        cin    = 1'b1;
      end
      OP_DBL: opnd_b = a;
      default: ;
    endcase

    sum = {1'b0, a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, cin};

    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (op)
      OP_NOT: res = ~a;
      OP_ADD, OP_SUB, OP_DBL: begin
        res = sum[WIDTH-1:0];
        c_f = sum[WIDTH];
        // Overflow: both adder inputs share a sign the result does not.
        v_f = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: res = '0;
    endcase

    alu_flags        = '0;
    alu_flags[FLG_Z] = (res == '0);
    alu_flags[FLG_N] = res[WIDTH-1];
    alu_flags[FLG_C] = c_f;
    alu_flags[FLG_V] = v_f;

    mul_lo           = mul_prod[WIDTH-1:0];
    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_lo == '0);
    mul_flags[FLG_N] = mul_lo[WIDTH-1];
    mul_flags[FLG_C] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLG_V] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  // Accept handling is shared between IDLE and DONE, so it is tested first;
  // the per-state branches only cover the non-accepting cases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        state     <= BUSY;
        out_valid <= 1'b0;
      end else begin
        state     <= DONE;
        y         <= res;
        flags     <= alu_flags;
        out_valid <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: ;
        BUSY: begin
          if (mul_done) begin
            state     <= DONE;
            y         <= mul_lo;
            flags     <= mul_flags;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;

  localparam int unsigned W = 4;
  localparam logic [2:0] T_NOT = 3'd0, T_ADD = 3'd1, T_SUB = 3'd2, T_DBL = 3'd3;
  localparam logic [2:0] T_XOR = 3'd6, T_MUL = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic [3:0]   flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  // Returns {y[3:0], Z, N, C, V}.
  function automatic logic [7:0] model(input int ai, input int bi, input int opi);
    int sa, sb, sr, full, yv, c, v;
    logic [7:0] r;
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    c = 0; v = 0; yv = 0;
    case (opi)
      0: yv = 15 - ai;
      1: begin full = ai + bi; yv = full % 16; c = int'(full > 15);
               sr = sa + sb; v = int'(sr > 7 || sr < -8); end
      2: begin yv = (ai - bi) & 15; c = int'(ai >= bi);
               sr = sa - sb; v = int'(sr > 7 || sr < -8); end
      3: begin full = 2 * ai; yv = full % 16; c = int'(full > 15);
               sr = 2 * sa; v = int'(sr > 7 || sr < -8); end
      4: yv = ai & bi;
      5: yv = ai | bi;
      6: yv = ai ^ bi;
      default: begin full = ai * bi; yv = full % 16;
               c = int'(full > 15); v = c; end
    endcase
    r[7:4] = 4'(yv);
    r[3]   = (yv == 0);
    r[2]   = (yv >= 8);
    r[1]   = c[0];
    r[0]   = v[0];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check latency/result, then optionally stall the consumer.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input logic [2:0] top,
                        input int stall, input string tag,
                        output logic [3:0] ry, output logic [3:0] rf);
    logic [7:0] e;
    int n;
    int lat;
    e = model(int'(ta), int'(tbv), int'(top));
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tbv; op = top; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk({tag, "_busy_in_ready"}, in_ready, 0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, (top == T_MUL) ? W + 1 : 1);
    chk({tag, "_y"}, y, e[7:4]);
    chk({tag, "_flags"}, flags, e[3:0]);
    ry = y;
    rf = flags;
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) begin
        step();
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_y"}, y, e[7:4]);
        chk({tag, "_hold_flags"}, flags, e[3:0]);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ry, rf, hy, hf;
    logic [3:0] ta, tbv;
    logic [7:0] e;
    logic [3:0] expq[$];

    // Reset state
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", flags, 0);
    chk("rst_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    step();

    // Directed arithmetic/logic cases ({Z,N,C,V})
    run_op(4'h7, 4'h1, T_ADD, 0, "add_7_1", ry, rf);
    chk("add_7_1_const_y", ry, 4'h8);  chk("add_7_1_const_f", rf, 4'b0101);
    run_op(4'hF, 4'h1, T_ADD, 0, "add_F_1", ry, rf);
    chk("add_F_1_const_y", ry, 4'h0);  chk("add_F_1_const_f", rf, 4'b1010);
    run_op(4'h3, 4'h5, T_SUB, 0, "sub_3_5", ry, rf);
    chk("sub_3_5_const_y", ry, 4'hE);  chk("sub_3_5_const_f", rf, 4'b0100);
    run_op(4'h8, 4'h1, T_SUB, 0, "sub_8_1", ry, rf);
    chk("sub_8_1_const_y", ry, 4'h7);  chk("sub_8_1_const_f", rf, 4'b0011);
    run_op(4'h9, 4'h0, T_DBL, 0, "dbl_9", ry, rf);
    chk("dbl_9_const_y", ry, 4'h2);    chk("dbl_9_const_f", rf, 4'b0011);
    run_op(4'h5, 4'h0, T_NOT, 0, "not_5", ry, rf);
    chk("not_5_const_y", ry, 4'hA);    chk("not_5_const_f", rf, 4'b0100);
    run_op(4'h5, 4'h3, T_MUL, 0, "mul_5_3", ry, rf);
    chk("mul_5_3_const_y", ry, 4'hF);  chk("mul_5_3_const_f", rf, 4'b0100);
    run_op(4'hF, 4'hF, T_MUL, 0, "mul_F_F", ry, rf);
    chk("mul_F_F_const_y", ry, 4'h1);  chk("mul_F_F_const_f", rf, 4'b0011);
    step();

    // Backpressure: result held while inputs toggle
    out_ready = 1'b0;
    a = 4'h6; b = 4'h5; op = T_ADD; in_valid = 1'b1;
    step();
    e = model(6, 5, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_y", y, e[7:4]);
    hy = y; hf = flags;
    repeat (3) begin
      a = 4'($urandom); b = 4'($urandom); op = 3'($urandom); in_valid = 1'b1;
      step();
      chk("bp_hold_y", y, e[7:4]);
      chk("bp_hold_flags", flags, e[3:0]);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    a = 4'h9; b = 4'h4; op = T_SUB; out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    e = model(9, 4, 2);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_y", y, e[7:4]);
    chk("bp_next_flags", flags, e[3:0]);
    step();
    chk("bp_idle_valid", out_valid, 0);

    // Streaming: 8 back-to-back XORs
    ta = 4'($urandom); tbv = 4'($urandom);
    a = ta; b = tbv; op = T_XOR; in_valid = 1'b1;
    expq.push_back(ta ^ tbv);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 7) begin
        ta = 4'($urandom); tbv = 4'($urandom);
        a = ta; b = tbv;
        expq.push_back(ta ^ tbv);
      end else begin
        in_valid = 1'b0;
      end
      chk("stream_valid", out_valid, 1);
      chk("stream_y", y, expq.pop_front());
    end
    step();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_queue_empty", expq.size(), 0);

    // Reset in the middle of a MUL
    run_op(4'h3, 4'h2, T_ADD, 0, "pre_rst", ry, rf);
    a = 4'h7; b = 4'h6; op = T_MUL; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", y, 0);
    chk("midrst_flags", flags, 0);
    #2 rst_n = 1'b1;
    step();
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    run_op(4'h2, 4'h2, T_ADD, 0, "postrst_add", ry, rf);
    chk("postrst_add_const_y", ry, 4'h4);
    step();

    // Randomized ops with random consumer stalls
    repeat (40) begin
      run_op(4'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(0, 2)),
             "rnd", ry, rf);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
